// File: rtl/pulpemu_clk_div_multi.sv
`timescale 1ns/1ps
// Multi-channel programmable clock divider: NB_CHANNELS divided clocks from clk_i, each with
// a runtime divisor and enable that take effect only on period boundaries or a global sync.
module pulpemu_clk_div_multi #(
   parameter int NB_CHANNELS = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 256,
   parameter int CH_W        = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   cfg_valid_i,
   output logic                   cfg_ready_o,
   input  logic [CH_W-1:0]        cfg_ch_i,
   input  logic [CNT_WIDTH-1:0]   cfg_div_i,
   input  logic                   cfg_en_i,
   input  logic                   sync_i,
   output logic [NB_CHANNELS-1:0] clk_o,
   output logic [NB_CHANNELS-1:0] tick_o
);

   localparam int NB_SLOTS = 1 << CH_W;

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t RST_DIV = cnt_t'(DEFAULT_DIV);

   // Divisors 0 and 1 are stored as written but run as a period of 2.
   function automatic cnt_t eff_div(input cnt_t div);
      return (div < cnt_t'(2)) ? cnt_t'(2) : div;
   endfunction

   function automatic cnt_t low_len(input cnt_t d);
      return d - (d >> 1);
   endfunction

   // Slots past the last channel read as never busy, so requests to them are accepted and dropped.
   logic [NB_SLOTS-1:0] busy;

   assign cfg_ready_o = !busy[cfg_ch_i];

   if (NB_SLOTS > NB_CHANNELS) begin : g_pad
      assign busy[NB_SLOTS-1:NB_CHANNELS] = '0;
   end

   for (genvar g = 0; g < NB_CHANNELS; g++) begin : g_ch
      cnt_t cnt_q, div_q, pend_div_q;
      cnt_t cnt_d, div_d, d_cur, d_nxt, l_nxt;
      logic en_q, pend_q, pend_en_q, clk_q, tick_q;
      logic en_d, pend_d, last, xfer, apply;

      always_comb begin
         // NOTE: every signal gets its default before any branch, so no path leaves one unassigned (no latch).
         d_cur  = eff_div(div_q);
         last   = (cnt_q == d_cur - cnt_t'(1));
         xfer   = cfg_valid_i && !pend_q && (cfg_ch_i == CH_W'(g));
         apply  = pend_q && (!en_q || last || sync_i);
         div_d  = div_q;
         en_d   = en_q;
         pend_d = pend_q | xfer;
         cnt_d  = '0;
         if (apply) begin
            div_d  = pend_div_q;
            en_d   = pend_en_q;
            pend_d = 1'b0;
         end else if (en_q && !last && !sync_i) begin
            cnt_d = cnt_q + cnt_t'(1);
         end
         // Outputs are registered from the next-cycle count and divisor.
         d_nxt = eff_div(div_d);
         l_nxt = low_len(d_nxt);
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         if (!rstn_i) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            en_q   <= 1'b1;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            clk_q  <= en_d && (cnt_d >= l_nxt);
            tick_q <= en_d && (cnt_d == l_nxt);
         end
      end

      // NOTE: the shadows are only consumed while pend_q is set, so they carry no reset.
      always_ff @(posedge clk_i) begin
         if (xfer) begin
            pend_div_q <= cfg_div_i;
            pend_en_q  <= cfg_en_i;
         end
      end

      assign busy[g]   = pend_q;
      assign clk_o[g]  = clk_q;
      assign tick_o[g] = tick_q;
   end

endmodule

// File: tb/tb_pulpemu_clk_div_multi.sv
`timescale 1ns/1ps
// Bench for pulpemu_clk_div_multi (3 channels): each scenario queues the expected clk/tick/ready
// word for every cycle as it drives stimulus, then pops and compares it at the falling edge.
module tb_pulpemu_clk_div_multi;

   localparam int NCH = 3;
   localparam int CW  = 2;
   localparam int DW  = 16;

   logic           clk_i  = 1'b0;
   logic           rstn_i = 1'b0;
   logic           cfg_valid_i;
   logic           cfg_ready_o;
   logic [CW-1:0]  cfg_ch_i;
   logic [DW-1:0]  cfg_div_i;
   logic           cfg_en_i;
   logic           sync_i;
   logic [NCH-1:0] clk_o;
   logic [NCH-1:0] tick_o;

   typedef struct packed {
      logic [NCH-1:0] clk;
      logic [NCH-1:0] tick;
      logic           rdy;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   pulpemu_clk_div_multi #(
      .NB_CHANNELS(NCH),
      .CNT_WIDTH  (DW),
      .DEFAULT_DIV(256)
   ) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_ready_o(cfg_ready_o),
      .cfg_ch_i   (cfg_ch_i),
      .cfg_div_i  (cfg_div_i),
      .cfg_en_i   (cfg_en_i),
      .sync_i     (sync_i),
      .clk_o      (clk_o),
      .tick_o     (tick_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected output of one channel at phase cnt of a period d: low for d-d/2 cycles, then high.
   function automatic void set_ch(inout exp_t e, input int ch, input bit on, input int cnt, input int d);
      int l;
      l = d - d / 2;
      e.clk[ch]  = on && (cnt >= l);
      e.tick[ch] = on && (cnt == l);
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input int ch, input int div, input logic en, input logic s);
      cfg_valid_i = v;
      cfg_ch_i    = CW'(ch);
      cfg_div_i   = DW'(div);
      cfg_en_i    = en;
      sync_i      = s;
   endtask

   task automatic hold_reset();
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      rstn_i = 1'b0;
      repeat (2) next_cycle();
   endtask

   task automatic sample(input exp_t e, output exp_t want, output exp_t obs);
      exp_q.push_back(e);
      @(negedge clk_i);
      want     = exp_q.pop_front();
      obs.clk  = clk_o;
      obs.tick = tick_o;
      obs.rdy  = cfg_ready_o;
   endtask

   task automatic test_reset();
      exp_t e, want, obs;
      hold_reset();
      checks++;
      if (clk_o !== '0 || tick_o !== '0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got clk=%b tick=%b rdy=%b want clk=000 tick=000 rdy=1",
                  clk_o, tick_o, cfg_ready_o);
      end
      rstn_i = 1'b1;
      for (int k = 0; k < 600; k++) begin
         e = '0;
         for (int c = 0; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = 1'b1;
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL reset_default k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   task automatic test_odd_div();
      exp_t e, want, obs;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 300; k++) begin
         drive(k == 10, 0, 5, 1'b1, 1'b0);
         e = '0;
         if (k < 256) set_ch(e, 0, 1'b1, k, 256);
         else         set_ch(e, 0, 1'b1, (k - 256) % 5, 5);
         for (int c = 1; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = !(k >= 11 && k <= 255);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL odd_div k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   task automatic test_degenerate_div();
      exp_t e, want, obs;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 320; k++) begin
         drive(k == 0 || k == 300, 0, (k == 0) ? 0 : 1, 1'b1, 1'b0);
         e = '0;
         if (k < 256) set_ch(e, 0, 1'b1, k, 256);
         else         set_ch(e, 0, 1'b1, (k - 256) % 2, 2);
         for (int c = 1; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = !((k >= 1 && k <= 255) || k == 301);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL degenerate_div k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   task automatic test_disable_boundary();
      exp_t e, want, obs;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 320; k++) begin
         drive(k == 200 || k == 300, 1, (k == 300) ? 4 : 256, k == 300, 1'b0);
         e = '0;
         set_ch(e, 0, 1'b1, k % 256, 256);
         set_ch(e, 2, 1'b1, k % 256, 256);
         if (k <= 255)     set_ch(e, 1, 1'b1, k, 256);
         else if (k < 302) set_ch(e, 1, 1'b0, 0, 4);
         else              set_ch(e, 1, 1'b1, (k - 302) % 4, 4);
         e.rdy = !((k >= 201 && k <= 255) || k == 301);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL disable_boundary k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   // The second sync lands on a cycle where ch0 and ch1 both wrap: one restart, not two.
   task automatic test_sync();
      exp_t e, want, obs;
      int   base01, base2;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 330; k++) begin
         drive(k <= 1, (k == 1) ? 1 : 0, (k == 1) ? 12 : 8, 1'b1, k == 261 || k == 285);
         base01 = (k < 262) ? 256 : 262;
         base2  = (k < 262) ? 0 : ((k < 286) ? 262 : 286);
         e = '0;
         if (k < 256) begin
            set_ch(e, 0, 1'b1, k, 256);
            set_ch(e, 1, 1'b1, k, 256);
         end else begin
            set_ch(e, 0, 1'b1, (k - base01) % 8, 8);
            set_ch(e, 1, 1'b1, (k - base01) % 12, 12);
         end
         set_ch(e, 2, 1'b1, (k - base2) % 256, 256);
         e.rdy = (k <= 1) || (k >= 256);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL sync k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, want, obs;
      bit   disc;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 520; k++) begin
         disc = (k >= 259 && k <= 262);
         if (disc) drive(1'b1, 3, 2, 1'b0, 1'b0);
         else      drive(k >= 5 && k <= 258, 0, 256, 1'b1, 1'b0);
         e = '0;
         for (int c = 0; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = (k <= 5) || (k == 256) || disc || (k >= 512);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL back_to_back k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e, want, obs;
      hold_reset();
      rstn_i = 1'b1;
      for (int k = 0; k <= 150; k++) begin
         drive(k == 3, 0, 5, 1'b1, 1'b0);
         e = '0;
         for (int c = 0; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = (k <= 3);
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL reset_mid_pre k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
      drive(1'b0, 0, 0, 1'b0, 1'b0);
      #2;
      rstn_i = 1'b0;
      #1;
      checks++;
      if (clk_o !== '0 || tick_o !== '0 || cfg_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_async got clk=%b tick=%b rdy=%b want clk=000 tick=000 rdy=1",
                  clk_o, tick_o, cfg_ready_o);
      end
      repeat (2) next_cycle();
      rstn_i = 1'b1;
      for (int k = 0; k <= 300; k++) begin
         e = '0;
         for (int c = 0; c < NCH; c++) set_ch(e, c, 1'b1, k % 256, 256);
         e.rdy = 1'b1;
         sample(e, want, obs);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL reset_mid_post k=%0d got clk=%b tick=%b rdy=%b want clk=%b tick=%b rdy=%b",
                     k, obs.clk, obs.tick, obs.rdy, want.clk, want.tick, want.rdy);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_odd_div();
      test_degenerate_div();
      test_disable_boundary();
      test_sync();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pulpemu_clk_div_multi.md
# pulpemu_clk_div_multi

Multi-channel programmable clock divider for the FPGA emulation top, the successor to the fixed-`DIVISOR` single-output reference divider. It generates `NB_CHANNELS` independent divided clocks from one FPGA clock, for example the 32768 Hz reference, the LED blink and the peripheral slow clocks. Each channel has a runtime-programmable divisor and an enable. Reconfiguration is glitch-free and takes effect on period boundaries. A global sync input phase-aligns all channels.

## Interface
- `NB_CHANNELS`, 2: number of output channels, ≥1.
- `CNT_WIDTH`, 16: divisor and counter width.
- `DEFAULT_DIV`, 256: per-channel divisor after reset; must be ≥2.
- `CH_W`, `max(1,$clog2(NB_CHANNELS))`: channel index width (derived).
- `clk_i` in 1: FPGA clock; the only clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `cfg_valid_i` in 1: a configuration request is present.
- `cfg_ready_o` out 1: the request can be accepted this cycle.
- `cfg_ch_i` in CH_W: target channel.
- `cfg_div_i` in CNT_WIDTH: new divisor (period in `clk_i` cycles).
- `cfg_en_i` in 1: new enable for the channel.
- `sync_i` in 1: restart all channels at phase 0.
- `clk_o` out NB_CHANNELS: divided clocks, one flop output per channel.
- `tick_o` out NB_CHANNELS: one-cycle pulse in the cycle where `clk_o[i]` rises.

## Operation
- **Per-channel state:**
  - `cnt` (CNT_WIDTH).
  - `div_q`.
  - `en_q`.
  - `pending`, plus the `pend_div` and `pend_en` shadows.
- **Effective divisor:** D = `max(div_q, 2)`. `cfg_div_i` values 0 and 1 are stored as given and behave as 2.
- **Phase split:** L = D − (D>>1) low cycles, then H = D>>1 high cycles. Odd D is high for one cycle less than it is low.
- **Counting (enabled channel):**
  - `cnt` runs 0…D−1, then wraps to 0.
  - `clk_o[i]` = 1 exactly in cycles where `cnt` ∈ [L, D−1]. It is registered, so it is computed from the next `cnt`.
  - `tick_o[i]` = 1 exactly in cycles where `cnt` == L.
- **Disabled channel:** `cnt` = 0, `clk_o` = 0, `tick_o` = 0, held.
- **Handshake:**
  - `cfg_ready_o` = !`pending[cfg_ch_i]`.
  - A transfer occurs on `cfg_valid_i & cfg_ready_o`.
  - On a transfer, `pend_div`/`pend_en` are captured and `pending` is set.
  - If `cfg_ch_i` ≥ NB_CHANNELS, the request is accepted (ready = 1) and discarded.
- **Apply condition:** `pending & (!en_q | cnt==D−1 | sync_i)`. On apply:
  - `div_q` ← `pend_div`, `en_q` ← `pend_en`.
  - `cnt` ← 0.
  - `pending` ← 0.
- **No partial periods from config:**
  - An enabled channel changes divisor or stops only at a wrap, when `clk_o` is about to go low.
  - Disabling therefore completes the current period first.
- **Sync:** `sync_i` = 1 forces `cnt` ← 0 on every enabled channel next cycle. This may truncate the current period; that is accepted by design.
- **Simultaneous events:**
  - Wrap and `sync_i` in the same cycle: a single restart.
  - Transfers to different channels in consecutive cycles are independent.
  - A transfer to a pending channel is impossible (ready = 0).

## Timing
- **Reset values:**
  - `clk_o` = 0, `tick_o` = 0, `cnt` = 0.
  - `div_q` = `DEFAULT_DIV`, `en_q` = 1 on all channels.
  - `pending` = 0, so `cfg_ready_o` = 1.
- **First edge after reset:** the first cycle after `rstn_i` deasserts has `cnt` = 0. The first `clk_o` rise is at cycle L (128 for the default).
- **Disabled channel, transfer in cycle t:**
  - Apply in t+1; `cnt` = 0 in t+2.
  - If enabled, the first rise is at t+2+L.
  - `cfg_ready_o` (for that channel) is high again in t+2.
- **Enabled channel, transfer in cycle t:** apply in the first cycle ≥ t+1 where `cnt` == D_old−1. The new period starts the next cycle.
- **Reset mid-operation:** all state returns to its reset value asynchronously. Pending requests are lost.
- **Structure:** no combinational path from `cfg_*` or `sync_i` to `clk_o`/`tick_o`.

## Test plan
- **Reset default:** release reset, observe 600 cycles → `clk_o[0]` and `clk_o[1]` first rise at cycle 128, period 256, 128 high; one tick per rise.
- **Odd divisor:** program ch0 `div` = 5, en = 1 → after the apply wrap, repeating pattern of 3 low and 2 high. `cfg_ready_o` is low from the transfer until the wrap cycle.
- **Degenerate divisor:** `div` = 0, then 1 → both give period 2 (1 low, 1 high) with a tick every 2 cycles.
- **Disable at boundary:** disable ch1 at `cnt` = 200 of a 256 period → `clk_o[1]` stays high until `cnt` = 255, then goes low and stays 0. Re-enable with `div` = 4 → first rise 4 cycles after the transfer (t+2+L, L = 2).
- **Sync:** ch0 `div` = 8, ch1 `div` = 12, pulse `sync_i` → both `cnt` = 0 next cycle. Rises at +4 and +6; coincident rises every 24 cycles.
- **Backpressure and discard:** transfer to ch0 (pending), then hold valid for ch0 → ready = 0 until the wrap. A request to channel index ≥ NB_CHANNELS (NB_CHANNELS = 3, CH_W = 2, `cfg_ch_i` = 3) is accepted immediately with no output change.
